pmod_adc_spi_capture: RTL

Parametrised multi-channel SPI capture engine for Pmod-class serial ADCs (AD1 family and successors). It drives a shared cs/sclk and shifts NUM_CH parallel sdin lines. It supports continuous polling or single-shot triggered conversion, and right-aligns DATA_BITS of each FRAME_BITS frame. Results are presented through a valid/ready output register with overrun detection; it sits between the Pmod pins and the AXI/stream wrapper.

---
 rtl/pmod_adc_pkg.sv | 38 +++
 rtl/pmod_adc_shift.sv | 24 ++
 rtl/pmod_adc_spi_capture.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pmod_adc_pkg.sv
// Shared definitions for the Pmod ADC SPI capture engine: FSM state
// encoding, counter sizing helpers and a parameter-legality check.
`ifndef PMOD_ADC_PKG_SV
`define PMOD_ADC_PKG_SV

// Elaboration-time guard against parameter sets the timing logic cannot honour.
`define PMOD_ADC_CHECK_PARAMS(CPB, DB, FB) \
    if ((((CPB) % 2) != 0) || ((CPB) < 4) || ((DB) > (FB)) || ((DB) < 1)) begin : g_bad_params \
        $error("pmod_adc: CLKS_PER_BIT must be even and >= 4, DATA_BITS must be 1..FRAME_BITS"); \
    end

package pmod_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_FRONT = 3'd2,
        ST_SHIFT = 3'd3,
        ST_BACK  = 3'd4
    } state_t;

    // Bits needed to hold any value 0..max_val (max_val >= 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`endif

// File: rtl/pmod_adc_shift.sv
// Single-channel MSB-first frame shift register with synchronous clear.
module pmod_adc_shift #(
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  sample,
    input  logic                  din,
    output logic [FRAME_BITS-1:0] q
);

    // Clear at frame start, otherwise shift in one bit per sample strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (sample) begin
            q <= {q[FRAME_BITS-2:0], din};
        end
    end

endmodule

// File: rtl/pmod_adc_spi_capture.sv
// Multi-channel SPI capture engine for Pmod-class serial ADCs. Drives a
// shared cs/sclk, shifts NUM_CH sdin lines in parallel and hands the
// right-aligned results to a valid/ready register with overrun tracking.
module pmod_adc_spi_capture
    import pmod_adc_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int FRAME_BITS       = 16,
    parameter int DATA_BITS        = 12,
    parameter int CLKS_PER_BIT     = 20,
    parameter int CLKS_BEFORE_DATA = 60,
    parameter int CLKS_AFTER_DATA  = 500,
    parameter int CLKS_BETWEEN     = 400
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          continuous,
    input  logic                          start,
    output logic                          cs,
    output logic                          sclk,
    input  logic [NUM_CH-1:0]             sdin,
    output logic [NUM_CH*DATA_BITS-1:0]   dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          busy
);

    localparam int CW = cnt_width(max4(CLKS_PER_BIT, CLKS_BEFORE_DATA,
                                       CLKS_AFTER_DATA, CLKS_BETWEEN));
    localparam int BW = cnt_width(FRAME_BITS);

    localparam logic [CW-1:0] BETWEEN_LAST = CW'(CLKS_BETWEEN - 1);
    localparam logic [CW-1:0] BEFORE_LAST  = CW'(CLKS_BEFORE_DATA - 1);
    localparam logic [CW-1:0] AFTER_LAST   = CW'(CLKS_AFTER_DATA - 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    // Last low-phase cycle of sclk: data has been stable for half a bit.
    localparam logic [CW-1:0] SAMPLE_AT    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FRAME_LAST   = BW'(FRAME_BITS - 1);

    `PMOD_ADC_CHECK_PARAMS(CLKS_PER_BIT, DATA_BITS, FRAME_BITS)

    state_t                             state;
    logic [CW-1:0]                      cnt;
    logic [BW-1:0]                      bit_idx;
    logic                               shift_clr;
    logic                               sample_en;
    logic                               frame_done;
    logic                               overrun_set;
    logic [NUM_CH-1:0][FRAME_BITS-1:0]  frame_q;
    logic [NUM_CH-1:0][DATA_BITS-1:0]   frame_data;
    logic                               unused_frame;

    assign shift_clr   = (state == ST_FRONT) && (cnt == BEFORE_LAST);
    assign sample_en   = (state == ST_SHIFT) && (cnt == SAMPLE_AT);
    assign frame_done  = (state == ST_SHIFT) && (cnt == BIT_LAST) && (bit_idx == FRAME_LAST);
    assign overrun_set = frame_done && dout_valid && !dout_ready;

    // Pin outputs are pure decodes of registered state, never of sdin.
    assign cs   = (state == ST_IDLE) || (state == ST_HOLD);
    assign sclk = !((state == ST_SHIFT) && (cnt <= SAMPLE_AT));
    assign busy = (state != ST_IDLE);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pmod_adc_shift #(
            .FRAME_BITS (FRAME_BITS)
        ) u_shift (
            .clk    (clk),
            .rst    (rst),
            .clr    (shift_clr),
            .sample (sample_en),
            .din    (sdin[k]),
            .q      (frame_q[k])
        );
        assign frame_data[k] = frame_q[k][DATA_BITS-1:0];
    end

    // Header bits above DATA_BITS are shifted in but deliberately dropped.
    assign unused_frame = ^frame_q;

    // Frame sequencer: HOLD (cs high) -> FRONT -> SHIFT -> BACK, repeat or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (continuous || start) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt == BETWEEN_LAST) begin
                        state <= ST_FRONT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_FRONT: begin
                    if (cnt == BEFORE_LAST) begin
                        state   <= ST_SHIFT;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == FRAME_LAST) state <= ST_BACK;
                        else                       bit_idx <= bit_idx + BW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BACK: begin
                    if (cnt == AFTER_LAST) begin
                        cnt   <= '0;
                        state <= continuous ? ST_HOLD : ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Result register: load wins over consume; overwrite of unconsumed data flags overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (frame_done) begin
                dout       <= frame_data;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (overrun_set)      overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

endmodule
